// File: rtl/ads_frame_reader.sv
// ADS1299 frame read sequencer: on DRDY it drives CS/SCLK, samples DOUT on each SCLK fall
// and forwards every bit to the 8-channel serial-to-parallel chain as a data/strobe pair.
module ads_frame_reader #(
   parameter int CLK_DIV     = 4,
   parameter int FRAME_BITS  = 216,
   parameter int STATUS_BITS = 24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   drdy_n,
   input  logic                   dout,
   output logic                   cs_n,
   output logic                   sclk,
   output logic                   serial_out,
   output logic                   serial_clk,
   output logic                   s2p_en,
   output logic [STATUS_BITS-1:0] status_word,
   output logic                   frame_done,
   output logic                   overrun
);

   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam int DIV_W = $clog2(CLK_DIV + 1);

   localparam logic [DIV_W-1:0]       DIV_ZERO  = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0]       DIV_ONE   = DIV_W'(1);
   localparam logic [DIV_W-1:0]       DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]       HOLD_LAST = DIV_W'(CLK_DIV - 2);
   localparam logic [CNT_W-1:0]       CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]       BITS_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0]       STAT_N    = CNT_W'(STATUS_BITS);
   localparam logic [STATUS_BITS-1:0] STAT_ZERO = {STATUS_BITS{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t                 state_r, state_s;
   logic [DIV_W-1:0]       div_cnt_r, div_cnt_s;
   logic [CNT_W-1:0]       bit_cnt_r, bit_cnt_s;
   logic                   sample_r, sample_s;
   logic [STATUS_BITS-1:0] shadow_r, shadow_s;
   logic                   sclk_r, sclk_s;
   logic                   serial_out_r, serial_out_s;
   logic                   serial_clk_r, serial_clk_s;
   logic                   s2p_en_r, s2p_en_s;
   logic                   cs_n_r, cs_n_s;
   logic [STATUS_BITS-1:0] status_word_r, status_word_s;
   logic                   frame_done_r, frame_done_s;
   logic                   overrun_r, overrun_s;
   logic                   busy_s;

   logic [1:0]             sync_r;
   logic                   sync_prev_r;
   logic                   drdy_fall_r;

   // DRDY synchroniser and registered falling-edge detector
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r      <= 2'b11;
         sync_prev_r <= 1'b1;
         drdy_fall_r <= 1'b0;
      end else begin
         sync_r      <= {sync_r[0], drdy_n};
         sync_prev_r <= sync_r[1];
         drdy_fall_r <= sync_prev_r & ~sync_r[1];
      end
   end

   // Next-state and next-output logic; all outputs are registered from these values
   always_comb begin
      state_s      = state_r;
      div_cnt_s    = div_cnt_r;
      bit_cnt_s    = bit_cnt_r;
      sclk_s       = 1'b0;
      sample_s     = 1'b0;
      serial_out_s = serial_out_r;
      serial_clk_s = 1'b0;
      shadow_s     = shadow_r;
      case (state_r)
         ST_IDLE: begin
            div_cnt_s = DIV_ZERO;
            bit_cnt_s = CNT_ZERO;
            if (drdy_fall_r && en) begin
               state_s  = ST_SETUP;
               shadow_s = STAT_ZERO;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (div_cnt_r == DIV_LAST) begin
               state_s   = ST_SHIFT;
               div_cnt_s = DIV_ZERO;
            end else begin
               div_cnt_s = div_cnt_r + DIV_ONE;
            end
         end
         ST_SHIFT: begin
            sclk_s = sclk_r;
            // A high-to-low SCLK transition samples DOUT; the strobe follows one clk later
            if (div_cnt_r == DIV_LAST) begin
               div_cnt_s = DIV_ZERO;
               sclk_s    = ~sclk_r;
               if (sclk_r) begin
                  serial_out_s = dout;
                  sample_s     = 1'b1;
               end else begin
                  serial_out_s = serial_out_r;
               end
            end else begin
               div_cnt_s = div_cnt_r + DIV_ONE;
            end
            if (sample_r) begin
               serial_clk_s = 1'b1;
               bit_cnt_s    = bit_cnt_r + CNT_ONE;
               if (bit_cnt_r < STAT_N) begin
                  shadow_s = {shadow_r[STATUS_BITS-2:0], serial_out_r};
               end else begin
                  shadow_s = shadow_r;
               end
               if (bit_cnt_r == BITS_LAST) begin
                  state_s   = ST_HOLD;
                  div_cnt_s = DIV_ZERO;
               end else begin
                  state_s = ST_SHIFT;
               end
            end else begin
               serial_clk_s = 1'b0;
            end
         end
         ST_HOLD: begin
            // HOLD starts one clk after the last SCLK fall, hence CLK_DIV-1 clks here
            if (div_cnt_r == HOLD_LAST) begin
               state_s   = ST_DONE;
               div_cnt_s = DIV_ZERO;
            end else begin
               div_cnt_s = div_cnt_r + DIV_ONE;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s   = ST_IDLE;
            div_cnt_s = DIV_ZERO;
            bit_cnt_s = CNT_ZERO;
         end
      endcase

      busy_s       = (state_s == ST_SETUP) || (state_s == ST_SHIFT) || (state_s == ST_HOLD);
      cs_n_s       = ~busy_s;
      s2p_en_s     = (state_s == ST_SHIFT) || serial_clk_s;
      frame_done_s = (state_s == ST_DONE);
      if (state_s == ST_DONE) begin
         status_word_s = shadow_r;
      end else begin
         status_word_s = status_word_r;
      end
      if (drdy_fall_r && (state_r != ST_IDLE)) begin
         overrun_s = 1'b1;
      end else begin
         overrun_s = overrun_r;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         div_cnt_r     <= DIV_ZERO;
         bit_cnt_r     <= CNT_ZERO;
         sample_r      <= 1'b0;
         shadow_r      <= STAT_ZERO;
         sclk_r        <= 1'b0;
         serial_out_r  <= 1'b0;
         serial_clk_r  <= 1'b0;
         s2p_en_r      <= 1'b0;
         cs_n_r        <= 1'b1;
         status_word_r <= STAT_ZERO;
         frame_done_r  <= 1'b0;
         overrun_r     <= 1'b0;
      end else begin
         state_r       <= state_s;
         div_cnt_r     <= div_cnt_s;
         bit_cnt_r     <= bit_cnt_s;
         sample_r      <= sample_s;
         shadow_r      <= shadow_s;
         sclk_r        <= sclk_s;
         serial_out_r  <= serial_out_s;
         serial_clk_r  <= serial_clk_s;
         s2p_en_r      <= s2p_en_s;
         cs_n_r        <= cs_n_s;
         status_word_r <= status_word_s;
         frame_done_r  <= frame_done_s;
         overrun_r     <= overrun_s;
      end
   end

   assign cs_n        = cs_n_r;
   assign sclk        = sclk_r;
   assign serial_out  = serial_out_r;
   assign serial_clk  = serial_clk_r;
   assign s2p_en      = s2p_en_r;
   assign status_word = status_word_r;
   assign frame_done  = frame_done_r;
   assign overrun     = overrun_r;

endmodule

// File: tb/tb_ads_frame_reader.sv
// Bench for ads_frame_reader: an ADC source model and an S2P chain model surround the DUT;
// frame contents and cycle timing are checked against values derived from the frame format.
module tb_ads_frame_reader;

   localparam int CLK_DIV     = 4;
   localparam int FRAME_BITS  = 216;
   localparam int STATUS_BITS = 24;
   localparam int NCH         = 8;
   localparam int CHAIN_BITS  = NCH * 24;
   localparam int CS_LAT      = 3;
   localparam int RISE_LAT    = 2 * CLK_DIV;
   localparam int DONE_LAT    = CLK_DIV + FRAME_BITS * 2 * CLK_DIV + CLK_DIV;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   en;
   logic                   drdy_n;
   logic                   dout;
   logic                   cs_n;
   logic                   sclk;
   logic                   serial_out;
   logic                   serial_clk;
   logic                   s2p_en;
   logic [STATUS_BITS-1:0] status_word;
   logic                   frame_done;
   logic                   overrun;

   int n_assert = 0;
   int n_fail   = 0;

   int cyc = 0;
   int sclk_rises, strobes, done_cnt, cs_falls, timing_err;
   int tx_idx, last_fall_cyc, last_strobe_cyc, s2p_fall_cyc, drdy_hold;
   logic sclk_q, cs_q, s2p_q;
   logic [FRAME_BITS-1:0] frame_v;
   logic [CHAIN_BITS-1:0] chain;
   logic [23:0] exp_status;
   logic [23:0] exp_ch [NCH];

   ads_frame_reader #(
      .CLK_DIV    (CLK_DIV),
      .FRAME_BITS (FRAME_BITS),
      .STATUS_BITS(STATUS_BITS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .drdy_n     (drdy_n),
      .dout       (dout),
      .cs_n       (cs_n),
      .sclk       (sclk),
      .serial_out (serial_out),
      .serial_clk (serial_clk),
      .s2p_en     (s2p_en),
      .status_word(status_word),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not reach the summary line");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample just after the edge, then run the ADC and S2P chain models
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (drdy_hold > 0) begin
         drdy_hold--;
         if (drdy_hold == 0) drdy_n = 1'b1;
      end
      if (cs_n) tx_idx = 0;
      if (sclk && !sclk_q) begin
         sclk_rises++;
         dout = (tx_idx < FRAME_BITS) ? frame_v[FRAME_BITS-1-tx_idx] : 1'b0;
         tx_idx++;
      end
      if (!sclk && sclk_q) last_fall_cyc = cyc;
      if (serial_clk) begin
         strobes++;
         chain = {chain[CHAIN_BITS-2:0], serial_out};
         if (cyc != last_fall_cyc + 1) timing_err++;
         last_strobe_cyc = cyc;
      end
      if (!s2p_en && s2p_q) s2p_fall_cyc = cyc;
      if (!cs_n && cs_q) cs_falls++;
      if (frame_done) done_cnt++;
      sclk_q = sclk;
      cs_q   = cs_n;
      s2p_q  = s2p_en;
   endtask

   task automatic pulse_drdy();
      drdy_n    = 1'b0;
      drdy_hold = 4;
   endtask

   task automatic build_frame();
      frame_v = FRAME_BITS'(exp_status);
      for (int n = 0; n < NCH; n++) frame_v = {frame_v[FRAME_BITS-25:0], exp_ch[n]};
   endtask

   task automatic randomize_frame();
      exp_status = 24'($urandom);
      for (int n = 0; n < NCH; n++) exp_ch[n] = 24'($urandom);
   endtask

   // Full frame from DRDY to DONE; optional en drop and extra DRDY at given strobe counts
   task automatic run_frame(input int drop_en_at, input int drdy_at);
      int t_drdy, t_cs, base_done;
      bit sent;
      sent = 1'b0;
      build_frame();
      base_done  = done_cnt;
      sclk_rises = 0;
      strobes    = 0;
      timing_err = 0;
      pulse_drdy();
      t_drdy = cyc + 1;
      for (int i = 0; i < 20 && cs_n; i++) tick();
      t_cs = cyc;
      check("cs_n_fall", 64'(cs_n), 64'(1'b0));
      check("cs_n_latency", 64'(t_cs - t_drdy), 64'(CS_LAT));
      for (int i = 0; i < 4 * RISE_LAT && !sclk; i++) tick();
      check("first_sclk_rise", 64'(cyc - t_cs), 64'(RISE_LAT));
      for (int i = 0; i < DONE_LAT + 100 && !frame_done; i++) begin
         if (strobes == drop_en_at) en = 1'b0;
         if (!sent && strobes == drdy_at) begin
            pulse_drdy();
            sent = 1'b1;
         end
         tick();
      end
      check("frame_done_latency", 64'(cyc - t_cs), 64'(DONE_LAT));
      check("cs_n_rise_at_done", 64'(cs_n), 64'(1'b1));
      check("status_word", 64'(status_word), 64'(exp_status));
      check("s2p_en_fall", 64'(s2p_fall_cyc - last_strobe_cyc), 64'(1));
      tick();
      check("frame_done_width", 64'(frame_done), 64'(1'b0));
      check("sclk_rises", 64'(sclk_rises), 64'(FRAME_BITS));
      check("strobes", 64'(strobes), 64'(FRAME_BITS));
      check("frame_done_count", 64'(done_cnt - base_done), 64'(1));
      check("strobe_timing", 64'(timing_err), 64'(0));
      for (int n = 0; n < NCH; n++)
         check($sformatf("ch%0d", n + 1), 64'(chain[CHAIN_BITS-1-24*n -: 24]), 64'(exp_ch[n]));
   endtask

   initial begin
      int saved_falls, saved_done;
      reset = 1'b1; en = 1'b0; drdy_n = 1'b1; dout = 1'b0;
      sclk_rises = 0; strobes = 0; done_cnt = 0; cs_falls = 0; timing_err = 0;
      tx_idx = 0; last_fall_cyc = -10; last_strobe_cyc = -10; s2p_fall_cyc = -10; drdy_hold = 0;
      sclk_q = 1'b0; cs_q = 1'b1; s2p_q = 1'b0;
      frame_v = '0; chain = '0; exp_status = 24'h000000;

      // reset and idle
      repeat (3) tick();
      check("rst_cs_n", 64'(cs_n), 64'(1'b1));
      check("rst_sclk", 64'(sclk), 64'(1'b0));
      check("rst_serial_out", 64'(serial_out), 64'(1'b0));
      check("rst_serial_clk", 64'(serial_clk), 64'(1'b0));
      check("rst_s2p_en", 64'(s2p_en), 64'(1'b0));
      check("rst_status_word", 64'(status_word), 64'(24'h000000));
      check("rst_frame_done", 64'(frame_done), 64'(1'b0));
      check("rst_overrun", 64'(overrun), 64'(1'b0));
      reset = 1'b0;
      en    = 1'b1;
      repeat (1000) tick();
      check("idle_sclk_edges", 64'(sclk_rises), 64'(0));
      check("idle_cs_falls", 64'(cs_falls), 64'(0));

      // fixed frame: status 0xC00000, CHn = 0x0A0000+n
      exp_status = 24'hC00000;
      for (int n = 0; n < NCH; n++) exp_ch[n] = 24'(32'h000A_0001 + 32'(n));
      run_frame(-1, -1);
      check("no_overrun_clean", 64'(overrun), 64'(1'b0));

      // random frames with random gaps
      for (int f = 0; f < 2; f++) begin
         randomize_frame();
         repeat ($urandom_range(5, 40)) tick();
         run_frame(-1, -1);
      end
      check("no_overrun_random", 64'(overrun), 64'(1'b0));

      // overrun: second DRDY at bit 100
      randomize_frame();
      run_frame(-1, 100);
      check("overrun_set", 64'(overrun), 64'(1'b1));
      saved_falls = cs_falls;
      repeat (60) tick();
      check("overrun_no_restart", 64'(cs_falls), 64'(saved_falls));
      randomize_frame();
      run_frame(-1, -1);
      check("overrun_sticky", 64'(overrun), 64'(1'b1));

      // en low: DRDY ignored
      en = 1'b0;
      saved_falls = cs_falls;
      for (int p = 0; p < 5; p++) begin
         pulse_drdy();
         repeat (20) tick();
      end
      check("en_low_no_frame", 64'(cs_falls), 64'(saved_falls));
      check("en_low_cs_n", 64'(cs_n), 64'(1'b1));

      // en dropped at bit 50: frame completes, nothing further starts
      en = 1'b1;
      randomize_frame();
      run_frame(50, -1);
      check("en_dropped_state", 64'(en), 64'(1'b0));
      saved_falls = cs_falls;
      pulse_drdy();
      repeat (100) tick();
      check("en_dropped_no_frame", 64'(cs_falls), 64'(saved_falls));
      en = 1'b1;

      // reset mid-frame at bit 120
      randomize_frame();
      build_frame();
      strobes = 0;
      pulse_drdy();
      for (int i = 0; i < 3000 && strobes < 120; i++) tick();
      check("reached_bit_120", 64'(strobes), 64'(120));
      saved_done = done_cnt;
      reset = 1'b1;
      tick();
      check("midrst_cs_n", 64'(cs_n), 64'(1'b1));
      check("midrst_sclk", 64'(sclk), 64'(1'b0));
      check("midrst_s2p_en", 64'(s2p_en), 64'(1'b0));
      check("midrst_frame_done", 64'(frame_done), 64'(1'b0));
      check("midrst_overrun", 64'(overrun), 64'(1'b0));
      check("midrst_status_word", 64'(status_word), 64'(24'h000000));
      reset = 1'b0;
      repeat (1800) tick();
      check("midrst_no_done", 64'(done_cnt), 64'(saved_done));
      check("midrst_idle_cs_n", 64'(cs_n), 64'(1'b1));
      randomize_frame();
      run_frame(-1, -1);
      check("post_rst_no_overrun", 64'(overrun), 64'(1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ads_frame_reader.md
# ads_frame_reader

Master-side read sequencer for the ADS1299 data frame; sits directly upstream of the 8-channel 24-bit serial-to-parallel chain.
- On each DRDY it lowers CS, generates SCLK and clocks in a full 216-bit frame (24-bit status word plus 8×24 channel bits).
- It forwards each sampled bit to the S2P chain as a data/strobe pair, with `s2p_en` framing the transfer.
- It captures the status word locally and pulses `frame_done` when the channel registers downstream hold a complete, aligned frame.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per SCLK half-period; legal range ≥ 2.
- `FRAME_BITS`, 216: bits per frame, status plus channels.
- `STATUS_BITS`, 24: leading bits captured into `status_word`.

Ports:
- `clk`, in, 1: single system clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `en`, in, 1: arms the reader; a frame is started only while high.
- `drdy_n`, in, 1: ADC data-ready, asynchronous, active-low.
- `dout`, in, 1: ADC serial data.
- `cs_n`, out, 1: ADC chip select, active-low.
- `sclk`, out, 1: ADC serial clock.
- `serial_out`, out, 1: sampled bit to the S2P chain.
- `serial_clk`, out, 1: one-clk-wide shift strobe to the S2P chain; the chain shifts `serial_out` on its rising edge.
- `s2p_en`, out, 1: high for the entire shift phase of a frame.
- `status_word`, out, 24: first `STATUS_BITS` bits of the last completed frame, MSB first.
- `frame_done`, out, 1: one-clk pulse when a frame completes.
- `overrun`, out, 1: sticky flag; set when DRDY falls while a frame is in progress.

## Operation
- `drdy_n` passes through a 2-FF synchroniser followed by a falling-edge detector, giving `drdy_fall`.
- State machine:
  - IDLE: on `drdy_fall && en`, go to SETUP.
  - SETUP: `cs_n` is low; stay `CLK_DIV` clks, then go to SHIFT.
  - SHIFT: `s2p_en` is high.
    - `sclk` toggles every `CLK_DIV` clks, starting low.
    - On each `sclk` high→low transition, `dout` is registered into `serial_out`. On the next clk, `serial_clk` pulses and `bit_cnt` increments.
    - After the `FRAME_BITS`-th strobe, go to HOLD with `sclk` low.
  - HOLD: `cs_n` stays low for `CLK_DIV` clks, then goes to DONE.
  - DONE: `cs_n` goes high, `frame_done` pulses for one clk, `status_word` updates; return to IDLE.
- During SHIFT, bits 0..`STATUS_BITS`-1 are also shifted MSB-first into a shadow register. The shadow register is copied to `status_word` only in DONE.
- Status bits flow through the S2P chain and fall out of its end. After `FRAME_BITS` strobes, CH1 sits in the last stage and CH8 in the first.
- `bit_cnt` width is ceil(log2(`FRAME_BITS`+1)); it clears in IDLE.
- If `drdy_fall` arrives in SETUP, SHIFT or HOLD: set `overrun`, ignore the edge, and let the current frame continue. `overrun` clears only on reset.
- If `drdy_fall` coincides with DONE, it is ignored and `overrun` is set. The next frame starts only on a later DRDY.
- Dropping `en` mid-frame does not abort the frame; the frame completes normally and no new frame starts.
- Reset mid-frame returns to IDLE on the next clk edge. The partial frame is discarded and `frame_done` does not pulse.

## Timing
- Reset values:
  - `cs_n` = 1
  - `sclk` = 0, `serial_out` = 0, `serial_clk` = 0, `s2p_en` = 0
  - `status_word` = 0, `frame_done` = 0, `overrun` = 0
- `drdy_n` low, sampled at edge k, gives `drdy_fall` at k+2; `cs_n` falls at k+3.
- `sclk` first rises `2*CLK_DIV` clks after `cs_n` falls (SETUP plus the first half-period).
- Each bit takes `2*CLK_DIV` clks. Shift phase = `FRAME_BITS*2*CLK_DIV` clks, which is 1728 at the defaults.
- Each `serial_clk` pulse occurs 1 clk after the `sclk` falling edge and `CLK_DIV-1` clks before the next rising edge. `serial_out` is stable from 1 clk before the strobe until the next sample.
- `frame_done`, the `cs_n` rise and the `status_word` update all occur on the same clk, `CLK_DIV` clks after the last `sclk` fall.
- `s2p_en` falls on the clk after the last `serial_clk` pulse.

## Test plan
- Reset and idle: hold `reset` for 3 clks with `drdy_n`=1.
  - Required: all outputs at reset values; no `sclk` edges for 1000 clks.
- Single frame with the ADC model sending status 0xC00000 and CHn = 0x0A0000+n:
  - Exactly 216 `sclk` rising edges and 216 `serial_clk` pulses.
  - `frame_done` pulses once; `status_word` = 0xC00000.
  - S2P model outputs CH1..CH8 = 0x0A0001..0x0A0008.
- Cycle timing at the defaults (`CLK_DIV`=4):
  - `cs_n` falls 3 clks after `drdy_n` falls.
  - First `sclk` rise occurs 8 clks later.
  - `frame_done` arrives 1736 clks after the `cs_n` fall.
- Overrun: second `drdy_n` fall at bit 100 of a frame.
  - Frame completes intact; `overrun` = 1 and stays set.
  - No second frame starts until the next DRDY after DONE.
- `en` control:
  - `en`=0 with DRDY toggling: `cs_n` stays high.
  - `en` dropped at bit 50: frame completes, `frame_done` pulses, no further frames start.
- Reset mid-frame at bit 120:
  - Next clk: `cs_n`=1, `sclk`=0, `s2p_en`=0, no `frame_done`.
  - Following DRDY: a clean 216-bit frame with correct data.
